ex_muldiv_unit: RTL and testbench

Multi-cycle RV32M multiply/divide engine in the EX stage. It consumes the operands and aluop held by the ID/EX pipeline register and drives `busywait` back to freeze the pipeline registers until the result is ready. Multiplies take 2 stall cycles; divides and remainders use an iterative 32-step divider.

---
 rtl/rv32m_pkg.sv | 33 +++
 rtl/ex_muldiv_unit_div_iter_core.sv | 78 +++++++
 rtl/ex_muldiv_unit.sv | 158 +++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M multiply/divide engine: operand width,
// M-extension aluop encodings and the controller state type.
package rv32m_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [4:0] OP_MUL    = 5'b01000;
    localparam logic [4:0] OP_MULH   = 5'b01001;
    localparam logic [4:0] OP_MULHSU = 5'b01010;
    localparam logic [4:0] OP_MULHU  = 5'b01011;
    localparam logic [4:0] OP_DIV    = 5'b01100;
    localparam logic [4:0] OP_DIVU   = 5'b01101;
    localparam logic [4:0] OP_REM    = 5'b01110;
    localparam logic [4:0] OP_REMU   = 5'b01111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

    // All eight M-ops share the 01xxx prefix.
    function automatic logic is_mop(input logic [4:0] op);
        return op[4:3] == 2'b01;
    endfunction

    // Divide-class ops have bit 2 set; bit 1 picks remainder; bit 0 marks unsigned.
    function automatic logic is_div_op(input logic [4:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_div_iter_core.sv
// Iterative restoring divider on unsigned magnitudes; one quotient bit per
// cycle after a load, with the final step's result exposed combinationally.
module div_iter_core
    import rv32m_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEPS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             last,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int unsigned CW = $clog2(STEPS + 1);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        // Partial remainder stays below the divisor, so a successful
        // subtraction always fits back into WIDTH bits.
        if (shifted >= {1'b0, dvs_q}) begin
            step_rem = diff[WIDTH-1:0];
            step_quo = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            step_rem = shifted[WIDTH-1:0];
            step_quo = {quo_q[WIDTH-2:0], 1'b0};
        end

        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        if (load) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
            cnt_d = CW'(STEPS);
        end else if (cnt_q != '0) begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

    assign last      = (cnt_q == CW'(1));
    assign quotient  = step_quo;
    assign remainder = step_rem;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage RV32M engine: 2-stall multiply, 32-step iterative divide, and a
// busywait that freezes the pipeline until the registered result is ready.
module ex_muldiv_unit
    import rv32m_pkg::*;
#(
    parameter int unsigned XLEN      = rv32m_pkg::XLEN,
    parameter int unsigned DIV_STEPS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [4:0]      aluop,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] result,
    output logic            done,
    output logic            busywait
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam int unsigned     PW      = 2 * XLEN + 2;

    muldiv_state_e   state_q, state_d;
    logic [4:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            done_q, done_d;

    logic            in_signed;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_load;
    logic            div_last;
    logic [XLEN-1:0] div_quo, div_rem;
    logic [XLEN-1:0] fix_quo, fix_rem;

    logic            mul_a_signed, mul_b_signed;
    logic [PW-1:0]   mul_a_ext, mul_b_ext;
    logic [PW-1:0]   product;

    div_iter_core #(
        .WIDTH (XLEN),
        .STEPS (DIV_STEPS)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .load      (div_load),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .last      (div_last),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        // Multiply on latched operands: 33-bit per-op extension, then a
        // full-width sign extension so a plain product yields the signed result.
        mul_a_signed = (op_q != OP_MULHU);
        mul_b_signed = (op_q == OP_MUL) || (op_q == OP_MULH);
        mul_a_ext    = {{(XLEN+2){mul_a_signed & a_q[XLEN-1]}}, a_q};
        mul_b_ext    = {{(XLEN+2){mul_b_signed & b_q[XLEN-1]}}, b_q};
        product      = mul_a_ext * mul_b_ext;

        in_signed = !aluop[0];
        a_neg     = in_signed & op_a[XLEN-1];
        b_neg     = in_signed & op_b[XLEN-1];
        a_mag     = a_neg ? -op_a : op_a;
        b_mag     = b_neg ? -op_b : op_b;

        fix_quo = neg_quo_q ? -div_quo : div_quo;
        fix_rem = neg_rem_q ? -div_rem : div_rem;

        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        done_d    = 1'b0;
        div_load  = 1'b0;
        busywait  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && is_mop(aluop)) begin
                    busywait = 1'b1;
                    op_d     = aluop;
                    a_d      = op_a;
                    b_d      = op_b;
                    if (!is_div_op(aluop)) begin
                        state_d = ST_MUL;
                    end else if (op_b == '0) begin
                        result_d = aluop[1] ? op_a : '1;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else if (in_signed && op_a == INT_MIN && op_b == '1) begin
                        result_d = aluop[1] ? '0 : INT_MIN;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        div_load  = 1'b1;
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        state_d   = ST_DIV;
                    end
                end
            end
            ST_MUL: begin
                busywait = 1'b1;
                result_d = (op_q == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
                done_d   = 1'b1;
                state_d  = ST_DONE;
            end
            ST_DIV: begin
                busywait = 1'b1;
                if (div_last) begin
                    result_d = op_q[1] ? fix_rem : fix_quo;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: hand-computed results and cycle-exact
// busywait/done timing for multiply, divide, special cases and reset abort.
module tb_ex_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  aluop;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] result;
    logic        done;
    logic        busywait;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_res;
    logic        saw_done;

    ex_muldiv_unit #(
        .XLEN      (32),
        .DIV_STEPS (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .aluop    (aluop),
        .op_a     (op_a),
        .op_b     (op_b),
        .result   (result),
        .done     (done),
        .busywait (busywait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a posedge; returns just after the edge that ends DONE.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        start = 1'b1;
        aluop = op;
        op_a  = a;
        op_b  = b;
        @(negedge clk);
        check({tag, "/busy_T"}, {31'b0, busywait}, 32'd1);
        @(posedge clk);
        #1;
        op_a = $urandom;
        op_b = $urandom;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            check($sformatf("%s/done_T+%0d", tag, k), {31'b0, done}, {31'b0, k == lat});
            check($sformatf("%s/busy_T+%0d", tag, k), {31'b0, busywait}, {31'b0, k < lat});
            if (k == lat) check({tag, "/result"}, result, exp);
            @(posedge clk);
            #1;
        end
        last_res = exp;
    endtask

    task automatic idle_check(input string tag);
        start = 1'b0;
        @(negedge clk);
        check({tag, "/idle_busy"}, {31'b0, busywait}, 32'd0);
        check({tag, "/idle_done"}, {31'b0, done}, 32'd0);
        check({tag, "/idle_hold"}, result, last_res);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        aluop = 5'b0;
        op_a  = '0;
        op_b  = '0;
        last_res = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("reset/result", result, 32'h0);
        check("reset/done", {31'b0, done}, 32'd0);
        check("reset/busy", {31'b0, busywait}, 32'd0);
        @(posedge clk);
        #1;

        run_op("mul", 5'b01000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
        idle_check("mul");
        run_op("mulh", 5'b01001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);
        idle_check("mulh");
        run_op("mulhu", 5'b01011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
        idle_check("mulhu");
        run_op("mulhsu", 5'b01010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 2);
        idle_check("mulhsu");

        run_op("divu", 5'b01101, 32'd100, 32'd7, 32'd14, 33);
        idle_check("divu");
        run_op("remu", 5'b01111, 32'd100, 32'd7, 32'd2, 33);
        idle_check("remu");
        run_op("div_neg", 5'b01100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33);
        idle_check("div_neg");
        run_op("rem_neg", 5'b01110, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33);
        idle_check("rem_neg");

        run_op("div_by0", 5'b01100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        idle_check("div_by0");
        run_op("rem_by0", 5'b01110, 32'd5, 32'd0, 32'd5, 1);
        idle_check("rem_by0");
        run_op("div_ovf", 5'b01100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        idle_check("div_ovf");
        run_op("rem_ovf", 5'b01110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
        idle_check("rem_ovf");

        // Abort a DIVU with a reset pulse ten cycles after acceptance.
        start = 1'b1;
        aluop = 5'b01101;
        op_a  = 32'd1000;
        op_b  = 32'd3;
        @(negedge clk);
        check("abort/busy_T", {31'b0, busywait}, 32'd1);
        @(posedge clk);
        #1;
        repeat (9) @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort/busy", {31'b0, busywait}, 32'd0);
        check("abort/done", {31'b0, done}, 32'd0);
        check("abort/result", result, 32'h0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busywait) saw_done = 1'b1;
        end
        check("abort/no_writeback", {31'b0, saw_done}, 32'd0);
        @(posedge clk);
        #1;
        run_op("mul_after_rst", 5'b01000, 32'd3, 32'd4, 32'd12, 2);
        idle_check("mul_after_rst");

        // Non-M-op with start held high must never stall or complete.
        start = 1'b1;
        aluop = 5'b00000;
        op_a  = 32'd9;
        op_b  = 32'd9;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("add/busy_%0d", i), {31'b0, busywait}, 32'd0);
            check($sformatf("add/done_%0d", i), {31'b0, done}, 32'd0);
            @(posedge clk);
            #1;
        end

        run_op("b2b_mul", 5'b01000, 32'd6, 32'd7, 32'd42, 2);
        run_op("b2b_divu", 5'b01101, 32'd1000, 32'd10, 32'd100, 33);
        idle_check("b2b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
